// File: rtl/gated_input_fifo_pkg.sv
// Shared constants and helpers for the gated input FIFO.
// The optional GATED_INPUT_FIFO_CHANGE_ONLY_EN build is handled in the top module.
package gated_input_fifo_pkg;

    localparam int DEFAULT_WIDTH = 2;
    localparam int DEFAULT_DEPTH = 4;

    // Occupancy change applied on a clock edge
    typedef enum logic [1:0] {
        LVL_HOLD = 2'b00,
        LVL_INC  = 2'b01,
        LVL_DEC  = 2'b10
    } level_op_e;

    // Ceiling log2, never less than 1 so a pointer always has at least one bit
    function automatic int clog2_f(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end else begin
            result = result;
        end
        return result;
    endfunction

endpackage

// File: rtl/gated_input_fifo_mem.sv
// DEPTH x WIDTH register array with one write port and an asynchronous read port.
// Storage is intentionally not reset; occupancy logic decides what is meaningful.
module gated_input_fifo_mem
    import gated_input_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [clog2_f(DEPTH)-1:0]  wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [clog2_f(DEPTH)-1:0]  rd_addr,
    output logic [WIDTH-1:0]           rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Sample storage write
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end else begin
            mem_r[wr_addr] <= mem_r[wr_addr];
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/gated_input_fifo.sv
// Enable-gated sampler feeding a DEPTH-entry FIFO with a valid/ready drain side.
// Define GATED_INPUT_FIFO_CHANGE_ONLY_EN to capture only samples that differ from the last one stored.
module gated_input_fifo
    import gated_input_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_enable,
    input  logic [WIDTH-1:0] in_bits,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_bits,
    output logic [CNT_W-1:0] level,
    output logic             overflow,
    input  logic             clr_ovf
);

    localparam int PTR_W = clog2_f(DEPTH);

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] level_r;
    logic             overflow_r;

    logic             cand_s;
    logic             full_s;
    logic             empty_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic [WIDTH-1:0] rd_data_s;
    level_op_e        level_op_s;

`ifdef GATED_INPUT_FIFO_CHANGE_ONLY_EN
    logic [WIDTH-1:0] last_captured_r;
    logic             primed_r;

    // A repeat of the last stored sample is not a capture candidate
    always_comb begin
        cand_s = bit_enable & (~primed_r | (in_bits != last_captured_r));
    end

    // Remember the most recently stored sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_captured_r <= {WIDTH{1'b0}};
            primed_r        <= 1'b0;
        end else if (push_s) begin
            last_captured_r <= in_bits;
            primed_r        <= 1'b1;
        end else begin
            last_captured_r <= last_captured_r;
            primed_r        <= primed_r;
        end
    end
`else
    // Every enabled cycle is a capture candidate
    always_comb begin
        cand_s = bit_enable;
    end
`endif

    // Handshake decode; a pop frees the slot a same-cycle push needs when full
    always_comb begin
        full_s  = (level_r == CNT_W'(DEPTH));
        empty_s = (level_r == {CNT_W{1'b0}});
        pop_s   = ~empty_s & out_ready;
        push_s  = cand_s & (~full_s | pop_s);
        drop_s  = cand_s & full_s & ~pop_s;
        if (push_s && !pop_s) begin
            level_op_s = LVL_INC;
        end else if (pop_s && !push_s) begin
            level_op_s = LVL_DEC;
        end else begin
            level_op_s = LVL_HOLD;
        end
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            level_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case (level_op_s)
                LVL_INC: level_r <= level_r + CNT_W'(1);
                LVL_DEC: level_r <= level_r - CNT_W'(1);
                default: level_r <= level_r;
            endcase
            // A new drop wins over a clear arriving in the same cycle
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_ovf) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    gated_input_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_s),
        .wr_addr (wr_ptr_r),
        .wr_data (in_bits),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_data_s)
    );

    // Empty FIFO reads as zero, like the disabled gate it replaces
    always_comb begin
        if (empty_s) begin
            out_bits = {WIDTH{1'b0}};
        end else begin
            out_bits = rd_data_s;
        end
    end

    assign out_valid = ~empty_s;
    assign level     = level_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_gated_input_fifo.sv
// Randomised and directed bench for gated_input_fifo against a queue-based model.
module tb_gated_input_fifo;

    localparam int W  = 2;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bit_enable = 1'b0;
    logic [W-1:0]  in_bits = '0;
    logic          out_ready = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          out_valid;
    logic [W-1:0]  out_bits;
    logic [CW-1:0] level;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q[$];
    bit           ovf_m;
`ifdef GATED_INPUT_FIFO_CHANGE_ONLY_EN
    logic [W-1:0] last_m;
    bit           primed_m;
`endif

    always #5 clk = ~clk;

    gated_input_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_enable (bit_enable),
        .in_bits    (in_bits),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_bits   (out_bits),
        .level      (level),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        ovf_m = 1'b0;
`ifdef GATED_INPUT_FIFO_CHANGE_ONLY_EN
        last_m   = '0;
        primed_m = 1'b0;
`endif
    endtask

    task automatic compare_model();
        logic [W-1:0] exp_bits;
        exp_bits = (q.size() != 0) ? q[0] : '0;
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("out_bits", 32'(out_bits), 32'(exp_bits));
        chk("level", 32'(level), 32'(q.size()));
        chk("overflow", 32'(overflow), 32'(ovf_m));
    endtask

    task automatic model_update(input logic en, input logic [W-1:0] b, input logic rdy,
                                input logic clr);
        bit cand;
        bit pop;
        bit push;
        cand = en;
`ifdef GATED_INPUT_FIFO_CHANGE_ONLY_EN
        cand = en && (!primed_m || b != last_m);
`endif
        pop  = (q.size() > 0) && rdy;
        push = cand && ((q.size() < D) || pop);
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back(b);
`ifdef GATED_INPUT_FIFO_CHANGE_ONLY_EN
            last_m   = b;
            primed_m = 1'b1;
`endif
        end
        if (cand && !push) ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;
    endtask

    // One clock of stimulus; outputs compared against the model 2 time units after the edge
    task automatic step(input logic en, input logic [W-1:0] b, input logic rdy, input logic clr);
        bit_enable = en;
        in_bits    = b;
        out_ready  = rdy;
        clr_ovf    = clr;
        @(posedge clk);
        model_update(en, b, rdy, clr);
        #2;
        compare_model();
    endtask

    task automatic do_reset();
        bit_enable = 1'b0;
        out_ready  = 1'b0;
        clr_ovf    = 1'b0;
        rst_n      = 1'b0;
        model_clear();
        #1;
        compare_model();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        model_clear();
        do_reset();

        // Idle after reset
        for (int i = 0; i < 5; i++) step(1'b0, 2'b00, 1'b0, 1'b0);
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_bits", 32'(out_bits), 32'd0);
        chk("idle_level", 32'(level), 32'd0);
        chk("idle_ovf", 32'(overflow), 32'd0);

        // Capture three, then drain in order
        step(1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 1'b0);
        step(1'b1, 2'b11, 1'b0, 1'b0);
        chk("fill3_level", 32'(level), 32'd3);
        chk("fill3_head", 32'(out_bits), 32'h1);
        step(1'b0, 2'b00, 1'b1, 1'b0);
        chk("drain_2nd", 32'(out_bits), 32'h2);
        step(1'b0, 2'b00, 1'b1, 1'b0);
        chk("drain_3rd", 32'(out_bits), 32'h3);
        step(1'b0, 2'b00, 1'b1, 1'b0);
        chk("drained_valid", 32'(out_valid), 32'd0);
        chk("drained_bits", 32'(out_bits), 32'd0);

        // Fill, overflow, clear priority
        step(1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 1'b0);
        step(1'b1, 2'b11, 1'b0, 1'b0);
        step(1'b1, 2'b00, 1'b0, 1'b0);
        step(1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 1'b0);
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_head", 32'(out_bits), 32'h1);
        step(1'b1, 2'b11, 1'b0, 1'b1);
        chk("ovf_set_beats_clr", 32'(overflow), 32'd1);
        step(1'b0, 2'b00, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Full with simultaneous push and pop across pointer wrap
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 2'((i + 1) % 4), 1'b1, 1'b0);
            chk("full_pp_level", 32'(level), 32'd4);
            chk("full_pp_ovf", 32'(overflow), 32'd0);
        end
        chk("full_pp_head", 32'(out_bits), 32'h3);

        // Asynchronous reset between edges
        step(1'b0, 2'b00, 1'b1, 1'b0);
        chk("pre_rst_level", 32'(level), 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_level", 32'(level), 32'd0);
        model_clear();
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Repeated samples
        step(1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 1'b0);
`ifdef GATED_INPUT_FIFO_CHANGE_ONLY_EN
        chk("repeat_level", 32'(level), 32'd2);
        chk("repeat_ovf", 32'(overflow), 32'd0);
        chk("repeat_head", 32'(out_bits), 32'h1);
`else
        chk("repeat_level", 32'(level), 32'd4);
        chk("repeat_ovf", 32'(overflow), 32'd1);
        chk("repeat_head", 32'(out_bits), 32'h1);
`endif

        // Randomised traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
